// File: rtl/ext_stage.sv
// ext_stage: registered immediate-extension stage between decode and execute.
//
// Widens an IMM_W-bit immediate to DATA_W bits in one of five modes (zero,
// sign, upper, branch offset, one-fill). Opcodes 5-7 produce zero data with
// out_err set. Producer and consumer are decoupled by a valid/ready handshake
// backed by a main register (drives the outputs) and one skid register, so the
// stage sustains one result per cycle and in_ready never depends
// combinationally on out_ready.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high; clears all state
//   flush      synchronous discard of both buffered entries
//   in_valid   producer offers in_op/in_imm this cycle
//   in_ready   stage accepts input this cycle
//   in_op      extension mode (0 zero, 1 sign, 2 upper, 3 branch, 4 one, 5-7 illegal)
//   in_imm     raw immediate
//   out_valid  out_data/out_err hold a result
//   out_ready  consumer takes the result this cycle
//   out_data   extended value
//   out_err    result came from an illegal in_op
module ext_stage #(
    parameter int IMM_W  = 16,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_op,
    input  logic [IMM_W-1:0]  in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_err
);

    localparam int EXT_W = DATA_W - IMM_W;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,   // main invalid
        ONE   = 2'd1,   // main valid, skid invalid
        FULL  = 2'd2    // main and skid valid
    } state_t;

    state_t state_reg, state_next;

    logic [DATA_W-1:0] main_data_reg;
    logic              main_err_reg;
    logic [DATA_W-1:0] skid_data_reg;
    logic              skid_err_reg;

    // ------------------------------------------------------------------
    // Extension datapath (combinational at the input)
    // ------------------------------------------------------------------
    logic [EXT_W-1:0]  sign_fill;
    logic [DATA_W-1:0] sext;
    logic [DATA_W-1:0] ext_data;
    logic              ext_err;

    generate
        for (genvar gi = 0; gi < EXT_W; gi++) begin : g_sign_fill
            assign sign_fill[gi] = in_imm[IMM_W-1];
        end
    endgenerate

    assign sext = {sign_fill, in_imm};

    always_comb begin
        ext_data = '0;
        ext_err  = 1'b0;
        case (in_op)
            3'd0:    ext_data = {{EXT_W{1'b0}}, in_imm};
            3'd1:    ext_data = sext;
            3'd2:    ext_data = {in_imm, {EXT_W{1'b0}}};
            // Branch offset: word offset to byte offset, top two bits fall off.
            3'd3:    ext_data = {sext[DATA_W-3:0], 2'b00};
            3'd4:    ext_data = {{EXT_W{1'b1}}, in_imm};
            default: ext_err  = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic xfer_in;
    logic xfer_out;

    // Only registered state and reset feed in_ready, keeping the ready path
    // from the consumer out of the producer's timing.
    assign in_ready  = (state_reg != FULL) & ~reset;
    assign out_valid = (state_reg != EMPTY);
    assign out_data  = main_data_reg;
    assign out_err   = main_err_reg;

    assign xfer_in  = in_valid & in_ready;
    assign xfer_out = out_valid & out_ready;

    // ------------------------------------------------------------------
    // Occupancy FSM: next state and register load enables
    // ------------------------------------------------------------------
    logic load_main_in;
    logic load_main_skid;
    logic load_skid;

    always_comb begin
        state_next     = state_reg;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        case (state_reg)
            EMPTY: begin
                if (xfer_in) begin
                    state_next   = ONE;
                    load_main_in = 1'b1;
                end
            end
            ONE: begin
                if (xfer_in && xfer_out) begin
                    load_main_in = 1'b1;
                end else if (xfer_in) begin
                    state_next = FULL;
                    load_skid  = 1'b1;
                end else if (xfer_out) begin
                    state_next = EMPTY;
                end
            end
            FULL: begin
                if (xfer_out) begin
                    state_next     = ONE;
                    load_main_skid = 1'b1;
                end
            end
            default: state_next = EMPTY;
        endcase
        // Flush drops both entries and whatever is offered this cycle.
        if (flush) begin
            state_next     = EMPTY;
            load_main_in   = 1'b0;
            load_main_skid = 1'b0;
            load_skid      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= EMPTY;
            main_data_reg <= '0;
            main_err_reg  <= 1'b0;
            skid_data_reg <= '0;
            skid_err_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (load_main_in) begin
                main_data_reg <= ext_data;
                main_err_reg  <= ext_err;
            end else if (load_main_skid) begin
                main_data_reg <= skid_data_reg;
                main_err_reg  <= skid_err_reg;
            end
            if (load_skid) begin
                skid_data_reg <= ext_data;
                skid_err_reg  <= ext_err;
            end
        end
    end

endmodule
